// File: rtl/mips_pkg.sv
// mips_pkg: opcode, funct and REGIMM rt encodings shared by the MIPS pipeline decoders.
package mips_pkg;
    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
    localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;
endpackage

// File: rtl/mips_ctrl.sv
// mips_ctrl: one-hot instruction decode of a MIPS word plus a sticky flag for unsupported encodings.
module mips_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] I,
    output logic lb, lbu, lh, lhu, lw,
    output logic sb, sh, sw,
    output logic add, addu, sub, subu, slt, sltu,
    output logic mult, multu, div, divu,
    output logic sll, srl, sra, sllv, srlv, srav,
    output logic and_, or_, xor_, nor_,
    output logic addi, addiu, andi, ori, xori, lui, slti, sltiu,
    output logic beq, bne, blez, bgtz, bltz, bgez,
    output logic j, jal, jalr, jr,
    output logic mfhi, mflo, mthi, mtlo,
    output logic R,
    output logic illegal_now,
    output logic illegal
);
    logic [5:0] op, fn;
    logic [4:0] rt;
    logic       sp, ri, illegal_d, illegal_q;
    logic       unused_fields;

    assign op = I[31:26];
    assign rt = I[20:16];
    assign fn = I[5:0];
    assign sp = op == OP_SPECIAL;
    assign ri = op == OP_REGIMM;
    assign unused_fields = ^{I[25:21], I[15:6]};

    assign j     = op == OP_J;
    assign jal   = op == OP_JAL;
    assign beq   = op == OP_BEQ;
    assign bne   = op == OP_BNE;
    assign blez  = op == OP_BLEZ;
    assign bgtz  = op == OP_BGTZ;
    assign addi  = op == OP_ADDI;
    assign addiu = op == OP_ADDIU;
    assign slti  = op == OP_SLTI;
    assign sltiu = op == OP_SLTIU;
    assign andi  = op == OP_ANDI;
    assign ori   = op == OP_ORI;
    assign xori  = op == OP_XORI;
    assign lui   = op == OP_LUI;
    assign lb    = op == OP_LB;
    assign lh    = op == OP_LH;
    assign lw    = op == OP_LW;
    assign lbu   = op == OP_LBU;
    assign lhu   = op == OP_LHU;
    assign sb    = op == OP_SB;
    assign sh    = op == OP_SH;
    assign sw    = op == OP_SW;
    assign bltz  = ri && rt == RT_BLTZ;
    assign bgez  = ri && rt == RT_BGEZ;

    assign sll   = sp && fn == FN_SLL;
    assign srl   = sp && fn == FN_SRL;
    assign sra   = sp && fn == FN_SRA;
    assign sllv  = sp && fn == FN_SLLV;
    assign srlv  = sp && fn == FN_SRLV;
    assign srav  = sp && fn == FN_SRAV;
    assign jr    = sp && fn == FN_JR;
    assign jalr  = sp && fn == FN_JALR;
    assign mfhi  = sp && fn == FN_MFHI;
    assign mthi  = sp && fn == FN_MTHI;
    assign mflo  = sp && fn == FN_MFLO;
    assign mtlo  = sp && fn == FN_MTLO;
    assign mult  = sp && fn == FN_MULT;
    assign multu = sp && fn == FN_MULTU;
    assign div   = sp && fn == FN_DIV;
    assign divu  = sp && fn == FN_DIVU;
    assign add   = sp && fn == FN_ADD;
    assign addu  = sp && fn == FN_ADDU;
    assign sub   = sp && fn == FN_SUB;
    assign subu  = sp && fn == FN_SUBU;
    assign and_  = sp && fn == FN_AND;
    assign or_   = sp && fn == FN_OR;
    assign xor_  = sp && fn == FN_XOR;
    assign nor_  = sp && fn == FN_NOR;
    assign slt   = sp && fn == FN_SLT;
    assign sltu  = sp && fn == FN_SLTU;

    // Only SPECIAL encodings that write rd; jr and the HI/LO writers are excluded.
    assign R = add | addu | sub | subu | and_ | or_ | xor_ | nor_ | slt | sltu |
               sll | srl | sra | sllv | srlv | srav | mfhi | mflo | jalr;

    assign illegal_now = ~|{lb, lbu, lh, lhu, lw, sb, sh, sw,
                            add, addu, sub, subu, slt, sltu, mult, multu, div, divu,
                            sll, srl, sra, sllv, srlv, srav, and_, or_, xor_, nor_,
                            addi, addiu, andi, ori, xori, lui, slti, sltiu,
                            beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr,
                            mfhi, mflo, mthi, mtlo};

    always_comb illegal_d = illegal_q | illegal_now;

    always_ff @(posedge clk or posedge reset)
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;

    assign illegal = illegal_q;
endmodule

// File: tb/tb_mips_ctrl.sv
// tb_mips_ctrl: directed vectors, full op/funct/rt sweep and random words against a table-driven decode model.
module tb_mips_ctrl;
    logic        clk = 1'b0, reset = 1'b0;
    logic [31:0] I = 32'h0;
    logic lb, lbu, lh, lhu, lw, sb, sh, sw, add, addu, sub, subu, slt, sltu;
    logic mult, multu, div, divu, sll, srl, sra, sllv, srlv, srav, and_, or_, xor_, nor_;
    logic addi, addiu, andi, ori, xori, lui, slti, sltiu, beq, bne, blez, bgtz, bltz, bgez;
    logic j, jal, jalr, jr, mfhi, mflo, mthi, mtlo, R, illegal_now, illegal;
    logic [49:0] f;
    int checks = 0, errors = 0;
    int op_idx[64], fn_idx[64];
    logic [49:0] r_mask;

    typedef struct {
        logic [31:0] i;
        logic [49:0] f;
        logic        r;
        logic        ill;
    } vec_t;
    vec_t vecs[12];

    mips_ctrl dut (
        .clk(clk), .reset(reset), .I(I),
        .lb(lb), .lbu(lbu), .lh(lh), .lhu(lhu), .lw(lw), .sb(sb), .sh(sh), .sw(sw),
        .add(add), .addu(addu), .sub(sub), .subu(subu), .slt(slt), .sltu(sltu),
        .mult(mult), .multu(multu), .div(div), .divu(divu),
        .sll(sll), .srl(srl), .sra(sra), .sllv(sllv), .srlv(srlv), .srav(srav),
        .and_(and_), .or_(or_), .xor_(xor_), .nor_(nor_),
        .addi(addi), .addiu(addiu), .andi(andi), .ori(ori), .xori(xori), .lui(lui),
        .slti(slti), .sltiu(sltiu), .beq(beq), .bne(bne), .blez(blez), .bgtz(bgtz),
        .bltz(bltz), .bgez(bgez), .j(j), .jal(jal), .jalr(jalr), .jr(jr),
        .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
        .R(R), .illegal_now(illegal_now), .illegal(illegal)
    );

    assign f = {mtlo, mthi, mflo, mfhi, jr, jalr, jal, j, bgez, bltz, bgtz, blez, bne, beq,
                sltiu, slti, lui, xori, ori, andi, addiu, addi, nor_, xor_, or_, and_,
                srav, srlv, sllv, sra, srl, sll, divu, div, multu, mult, sltu, slt, subu, sub,
                addu, add, sw, sh, sb, lw, lhu, lh, lbu, lb};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: I=%h got %h expected %h", name, I, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] ins, output logic [49:0] ef, output logic er);
        int idx;
        logic [5:0] op;
        op = ins[31:26];
        if (op == 0)      idx = fn_idx[ins[5:0]];
        else if (op == 1) idx = ins[20:16] == 0 ? 40 : ins[20:16] == 1 ? 41 : -1;
        else              idx = op_idx[op];
        ef = '0;
        er = 1'b0;
        if (idx >= 0) begin
            ef[idx] = 1'b1;
            er = op == 0 && r_mask[idx];
        end
    endfunction

    task automatic check_model(input string tag);
        logic [49:0] ef;
        logic er;
        model(I, ef, er);
        chk({tag, "_flags"}, 64'(f), 64'(ef));
        chk({tag, "_R"}, 64'(R), 64'(er));
        chk({tag, "_illnow"}, 64'(illegal_now), 64'(ef == '0));
        chk({tag, "_onehot"}, 64'($countones(f) <= 1), 64'd1);
    endtask

    initial begin
        int rlist[19] = '{8, 9, 10, 11, 12, 13, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 44, 46, 47};
        foreach (op_idx[k]) begin op_idx[k] = -1; fn_idx[k] = -1; end
        op_idx[6'h02] = 42; op_idx[6'h03] = 43; op_idx[6'h04] = 36; op_idx[6'h05] = 37;
        op_idx[6'h06] = 38; op_idx[6'h07] = 39; op_idx[6'h08] = 28; op_idx[6'h09] = 29;
        op_idx[6'h0A] = 34; op_idx[6'h0B] = 35; op_idx[6'h0C] = 30; op_idx[6'h0D] = 31;
        op_idx[6'h0E] = 32; op_idx[6'h0F] = 33; op_idx[6'h20] = 0;  op_idx[6'h21] = 2;
        op_idx[6'h23] = 4;  op_idx[6'h24] = 1;  op_idx[6'h25] = 3;  op_idx[6'h28] = 5;
        op_idx[6'h29] = 6;  op_idx[6'h2B] = 7;
        fn_idx[6'h00] = 18; fn_idx[6'h02] = 19; fn_idx[6'h03] = 20; fn_idx[6'h04] = 21;
        fn_idx[6'h06] = 22; fn_idx[6'h07] = 23; fn_idx[6'h08] = 45; fn_idx[6'h09] = 44;
        fn_idx[6'h10] = 46; fn_idx[6'h11] = 48; fn_idx[6'h12] = 47; fn_idx[6'h13] = 49;
        fn_idx[6'h18] = 14; fn_idx[6'h19] = 15; fn_idx[6'h1A] = 16; fn_idx[6'h1B] = 17;
        fn_idx[6'h20] = 8;  fn_idx[6'h21] = 9;  fn_idx[6'h22] = 10; fn_idx[6'h23] = 11;
        fn_idx[6'h24] = 24; fn_idx[6'h25] = 25; fn_idx[6'h26] = 26; fn_idx[6'h27] = 27;
        fn_idx[6'h2A] = 12; fn_idx[6'h2B] = 13;
        r_mask = '0;
        foreach (rlist[k]) r_mask[rlist[k]] = 1'b1;

        vecs[0]  = '{32'h8C080004, 50'd1 << 4,  1'b0, 1'b0};
        vecs[1]  = '{32'h00221821, 50'd1 << 9,  1'b1, 1'b0};
        vecs[2]  = '{32'h03E00008, 50'd1 << 45, 1'b0, 1'b0};
        vecs[3]  = '{32'h04000003, 50'd1 << 40, 1'b0, 1'b0};
        vecs[4]  = '{32'h04210003, 50'd1 << 41, 1'b0, 1'b0};
        vecs[5]  = '{32'h04420003, 50'd0,       1'b0, 1'b1};
        vecs[6]  = '{32'h00000000, 50'd1 << 18, 1'b1, 1'b0};
        vecs[7]  = '{32'hFC000000, 50'd0,       1'b0, 1'b1};
        vecs[8]  = '{32'h00430018, 50'd1 << 14, 1'b0, 1'b0};
        vecs[9]  = '{32'h00400809, 50'd1 << 44, 1'b1, 1'b0};
        vecs[10] = '{32'h00001012, 50'd1 << 47, 1'b1, 1'b0};
        vecs[11] = '{32'h3C01ABCD, 50'd1 << 33, 1'b0, 1'b0};

        #1 reset = 1'b1;
        #1 chk("reset_illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        I = 32'hFC000000;
        @(posedge clk); #1;
        chk("reset_wins", 64'(illegal), 64'd0);
        I = 32'h8C080004; #1;
        chk("decode_in_reset", 64'(f), 64'(50'd1 << 4));
        @(negedge clk) reset = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk) I = vecs[k].i;
            #1;
            chk("vec_flags", 64'(f), 64'(vecs[k].f));
            chk("vec_R", 64'(R), 64'(vecs[k].r));
            chk("vec_illnow", 64'(illegal_now), 64'(vecs[k].ill));
            check_model("vec_model");
        end

        reset = 1'b1; #1 reset = 1'b0;
        @(negedge clk) I = 32'h8C080004;
        @(posedge clk); #1;
        chk("legal_no_set", 64'(illegal), 64'd0);
        @(negedge clk) I = 32'hFC000000;
        #1 chk("no_set_before_edge", 64'(illegal), 64'd0);
        @(posedge clk); #1;
        chk("set_on_edge", 64'(illegal), 64'd1);
        @(negedge clk) I = 32'h00221821;
        @(posedge clk); #1;
        chk("sticky", 64'(illegal), 64'd1);
        @(negedge clk); #2 reset = 1'b1;
        #1 chk("async_clear", 64'(illegal), 64'd0);
        @(negedge clk) reset = 1'b0;

        for (int op = 0; op < 64; op++)
            for (int fn = 0; fn < 64; fn++)
                for (int rt = 0; rt < 3; rt++) begin
                    I = {6'(op), 5'($urandom), 5'(rt), 10'($urandom), 6'(fn)};
                    #1 check_model("sweep");
                end

        for (int n = 0; n < 3000; n++) begin
            I = $urandom;
            if (n % 3 == 0) I[31:26] = 6'd0;
            else if (n % 3 == 1) I[31:26] = $urandom_range(0, 1) == 0 ? 6'd1 : I[31:26];
            #1 check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
